// File: rtl/rgb2gray_pkg.sv
// Shared constants, FSM state type and width helpers for the RGB-to-gray stream.
// RGB2GRAY_WEIGHTED_EN selects the weighted-luminance build (wider accumulator).
package rgb2gray_pkg;

    localparam int COEF_R  = 77;
    localparam int COEF_G  = 150;
    localparam int COEF_B  = 29;
    localparam int ROUND_C = 128;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_CALC    = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    // ceil(2^(w+1) / 3): reciprocal of 3 scaled by 2^(w+1)
    function automatic int avg_k(input int color_w);
        return ((1 << (color_w + 1)) + 2) / 3;
    endfunction

    function automatic int acc_width(input int color_w);
`ifdef RGB2GRAY_WEIGHTED_EN
        return color_w + 9;
`else
        return color_w + 2;
`endif
    endfunction

endpackage

// File: rtl/rgb2gray_mac.sv
// Coefficient select and multiply-accumulate over the three channel beats.
// RGB2GRAY_WEIGHTED_EN adds the BT.601 coefficient table; otherwise every weight is 1.
module rgb2gray_mac
    import rgb2gray_pkg::*;
#(
    parameter int COLOR_W = 8,
    parameter int ACC_W   = acc_width(COLOR_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               load,
    input  logic               add,
    input  logic [1:0]         ch,
    input  logic               mode,
    input  logic [COLOR_W-1:0] data,
    output logic [ACC_W-1:0]   acc
);

    logic [ACC_W-1:0] term;

`ifdef RGB2GRAY_WEIGHTED_EN
    logic [7:0] coef;

    // A load is always the R channel, even when it restarts a broken pixel
    always_comb begin
        coef = 8'd1;
        if (mode) begin
            if (load)            coef = 8'(COEF_R);
            else if (ch == 2'd1) coef = 8'(COEF_G);
            else                 coef = 8'(COEF_B);
        end
    end

    assign term = ACC_W'(coef) * ACC_W'(data);
`else
    logic unused_sel;
    assign unused_sel = ^{mode, ch};
    assign term       = ACC_W'(data);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     acc <= '0;
        else if (clear) acc <= '0;
        else if (load)  acc <= term;
        else if (add)   acc <= acc + term;
    end

endmodule

// File: rtl/rgb2gray_stream.sv
// Streaming RGB-to-gray converter: R,G,B beats in, one gray sample per pixel out.
// RGB2GRAY_WEIGHTED_EN enables the mode_i-selected BT.601 weighted path.
module rgb2gray_stream
    import rgb2gray_pkg::*;
#(
    parameter int COLOR_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear_i,
    input  logic               mode_i,
    input  logic               in_valid_i,
    input  logic               in_sop_i,
    input  logic [COLOR_W-1:0] in_data_i,
    output logic               in_ready_o,
    output logic               out_valid_o,
    output logic [COLOR_W-1:0] out_data_o,
    input  logic               out_ready_i,
    output logic               err_o
);

    localparam int ACC_W  = acc_width(COLOR_W);
    localparam int K_AVG  = avg_k(COLOR_W);
    localparam int PROD_W = ACC_W + COLOR_W + 2;

    state_t             state_q, state_d;
    logic [1:0]         ch_q, ch_d;
    logic               err_q, err_d;
    logic               mac_load, mac_add, mac_clear, res_load;
    logic               coef_mode, beat;
    logic [ACC_W-1:0]   acc_p0;
    logic [COLOR_W-1:0] gray_p0, gray_p1;
    logic               vld_p1;

    function automatic logic [COLOR_W-1:0] sat_gray(input logic [PROD_W-1:0] v);
        if (|v[PROD_W-1:COLOR_W]) return '1;
        return v[COLOR_W-1:0];
    endfunction

    function automatic logic [PROD_W-1:0] avg_scale(input logic [ACC_W-1:0] a);
        return (PROD_W'(a) * PROD_W'(K_AVG)) >> (COLOR_W + 1);
    endfunction

`ifdef RGB2GRAY_WEIGHTED_EN
    logic mode_q;

    function automatic logic [PROD_W-1:0] round_weighted(input logic [ACC_W-1:0] a);
        return (PROD_W'(a) + PROD_W'(ROUND_C)) >> 8;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)       mode_q <= 1'b0;
        else if (mac_load) mode_q <= mode_i;
    end

    // The R beat uses mode_i directly since mode_q only captures it on that edge
    assign coef_mode = mac_load ? mode_i : mode_q;
`else
    logic unused_mode;
    assign unused_mode = mode_i;
    assign coef_mode   = 1'b0;
`endif

    assign in_ready_o = (state_q == ST_COLLECT);
    assign beat       = in_valid_i & in_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_COLLECT;
            ch_q    <= 2'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        err_d     = 1'b0;
        mac_load  = 1'b0;
        mac_add   = 1'b0;
        mac_clear = 1'b0;
        res_load  = 1'b0;
        case (state_q)
            ST_COLLECT: begin
                if (beat) begin
                    if (in_sop_i) begin
                        mac_load = 1'b1;
                        ch_d     = 2'd1;
                        err_d    = (ch_q != 2'd0);
                    end else if (ch_q == 2'd0) begin
                        err_d = 1'b1;
                    end else begin
                        mac_add = 1'b1;
                        if (ch_q == 2'd2) begin
                            ch_d    = 2'd0;
                            state_d = ST_CALC;
                        end else begin
                            ch_d = ch_q + 2'd1;
                        end
                    end
                end
            end
            ST_CALC: begin
                res_load = 1'b1;
                state_d  = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready_i) state_d = ST_COLLECT;
            end
            default: state_d = ST_COLLECT;
        endcase
        if (clear_i) begin
            state_d   = ST_COLLECT;
            ch_d      = 2'd0;
            err_d     = 1'b0;
            mac_load  = 1'b0;
            mac_add   = 1'b0;
            res_load  = 1'b0;
            mac_clear = 1'b1;
        end
    end

    rgb2gray_mac #(
        .COLOR_W (COLOR_W),
        .ACC_W   (ACC_W)
    ) u_mac (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .clear (mac_clear),
        .load  (mac_load),
        .add   (mac_add),
        .ch    (ch_q),
        .mode  (coef_mode),
        .data  (in_data_i),
        .acc   (acc_p0)
    );

    // ---- result stage: scale/round the accumulated sum during CALC ----
    always_comb begin
        gray_p0 = sat_gray(avg_scale(acc_p0));
`ifdef RGB2GRAY_WEIGHTED_EN
        if (mode_q) gray_p0 = sat_gray(round_weighted(acc_p0));
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)       gray_p1 <= '0;
        else if (clear_i)  gray_p1 <= '0;
        else if (res_load) gray_p1 <= gray_p0;
    end

    assign vld_p1      = (state_q == ST_HOLD);
    assign out_valid_o = vld_p1;
    assign out_data_o  = gray_p1;
    assign err_o       = err_q;

endmodule
